// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types, mode constants and lane-count helper for the
//               byte-enabled pipelined block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } bramState_t;

    localparam int WRITE_FIRST_MODE = 1;
    localparam int READ_FIRST_MODE  = 0;

    // Returns 0 when the word does not split evenly into byte lanes.
    function automatic int numBytes(input int dataWidth, input int byteWidth);
        if (byteWidth <= 0 || (dataWidth % byteWidth) != 0) begin
            return 0;
        end
        return dataWidth / byteWidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_clear_ctrl
// Description : Post-reset clear sequencer; sweeps every address with a zero
//               write, then raises ready.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    output logic                  clearWe,
    output logic [ADDR_WIDTH-1:0] clearAddr
);

    localparam bramState_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    bramState_t            r_state;
    bramState_t            w_stateNext;
    logic [ADDR_WIDTH-1:0] r_clearCount;
    logic                  r_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_RESET_STATE;
            r_clearCount <= '0;
            r_ready      <= (c_RESET_STATE == READY);
        end else begin
            r_state <= w_stateNext;
            r_ready <= (w_stateNext == READY);
            if (r_state == CLEAR) begin
                r_clearCount <= r_clearCount + 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        clearWe     = 1'b0;
        case (r_state)
            CLEAR: begin
                clearWe = 1'b1;
                if (r_clearCount == '1) begin
                    w_stateNext = READY;
                end
            end
            READY: begin
            end
            default: w_stateNext = c_RESET_STATE;
        endcase
    end

    assign ready     = r_ready;
    assign clearAddr = r_clearCount;

endmodule
`default_nettype wire

// File: rtl/bram_be_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : bram_be_pipelined
// Description : Block RAM with byte-lane writes, 1/2-cycle read latency,
//               selectable collision policy and optional post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_be_pipelined
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             ready,
    input  logic                             readEnable,
    input  logic [ADDR_WIDTH-1:0]            readAddress,
    output logic [DATA_WIDTH-1:0]            readData,
    output logic                             readValid,
    input  logic                             writeEnable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]            writeAddress,
    input  logic [DATA_WIDTH-1:0]            writeData
);

    localparam int c_NUM_BYTES = numBytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int c_MEM_DEPTH = 1 << ADDR_WIDTH;

    if (c_NUM_BYTES == 0) begin : g_badByteWidth
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0]  r_mem [c_MEM_DEPTH];
    logic                   w_clearWe;
    logic [ADDR_WIDTH-1:0]  w_clearAddr;
    logic                   w_wrEn;
    logic [ADDR_WIDTH-1:0]  w_wrAddr;
    logic [DATA_WIDTH-1:0]  w_wrData;
    logic [c_NUM_BYTES-1:0] w_wrMask;
    logic                   w_accept;
    logic                   w_collide;
    logic [DATA_WIDTH-1:0]  w_readWord;
    logic                   r_s1Valid;
    logic [DATA_WIDTH-1:0]  r_s1Data;

    bram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clearCtrl (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .clearWe   (w_clearWe),
        .clearAddr (w_clearAddr)
    );

    // The clear engine owns the write port until ready rises.
    always_comb begin
        if (ready) begin
            w_wrEn   = writeEnable;
            w_wrAddr = writeAddress;
            w_wrData = writeData;
            w_wrMask = writeByteEnable;
        end else begin
            w_wrEn   = w_clearWe;
            w_wrAddr = w_clearAddr;
            w_wrData = '0;
            w_wrMask = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && w_wrEn) begin
            for (int i = 0; i < c_NUM_BYTES; i++) begin
                if (w_wrMask[i]) begin
                    r_mem[w_wrAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wrData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign w_accept  = ready & readEnable;
    assign w_collide = readEnable & writeEnable & (readAddress == writeAddress);

    always_comb begin
        w_readWord = r_mem[readAddress];
        if (WRITE_FIRST == WRITE_FIRST_MODE && w_collide) begin
            for (int i = 0; i < c_NUM_BYTES; i++) begin
                if (writeByteEnable[i]) begin
                    w_readWord[i*BYTE_WIDTH +: BYTE_WIDTH] = writeData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
        end else begin
            r_s1Valid <= w_accept;
            r_s1Data  <= w_accept ? w_readWord : '0;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign readValid = r_s1Valid;
        assign readData  = r_s1Data;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_s2Valid;
        logic [DATA_WIDTH-1:0] r_s2Data;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_s2Valid <= 1'b0;
                r_s2Data  <= '0;
            end else begin
                r_s2Valid <= r_s1Valid;
                r_s2Data  <= r_s1Data;
            end
        end

        assign readValid = r_s2Valid;
        assign readData  = r_s2Data;
    end else begin : g_badLatency
        $error("READ_LATENCY must be 1 or 2");
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_be_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_be_pipelined
// Description : Directed bench for two RAM flavours (latency 1 write-first,
//               latency 2 read-first) sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_be_pipelined;

    localparam int c_DEPTH = 16;

    logic        clock;
    logic        reset;
    logic        readEnable;
    logic [3:0]  readAddress;
    logic        writeEnable;
    logic [3:0]  writeByteEnable;
    logic [3:0]  writeAddress;
    logic [31:0] writeData;

    logic        readyA, readValidA, readyB, readValidB;
    logic [31:0] readDataA, readDataB;

    int errors = 0;
    int checks = 0;

    bram_be_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) u_dutA (
        .clock(clock), .reset(reset), .ready(readyA),
        .readEnable(readEnable), .readAddress(readAddress),
        .readData(readDataA), .readValid(readValidA),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData)
    );

    bram_be_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) u_dutB (
        .clock(clock), .reset(reset), .ready(readyB),
        .readEnable(readEnable), .readAddress(readAddress),
        .readData(readDataB), .readValid(readValidB),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the clear leaves every word zero before traffic opens,
    // and each accepted read yields one result per flavour, aged by latency.
    logic [31:0] mMem [c_DEPTH];
    int unsigned mEdges;
    logic        mHistV [2];
    logic [31:0] mHistA [2];
    logic [31:0] mHistB [2];
    logic        mV;
    logic [31:0] mOld, mA;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mEdges = 0;
            for (int i = 0; i < c_DEPTH; i++) mMem[i] = 32'h0;
            for (int i = 0; i < 2; i++) begin
                mHistV[i] = 1'b0;
                mHistA[i] = 32'h0;
                mHistB[i] = 32'h0;
            end
        end else begin
            mV   = (mEdges >= c_DEPTH) && readEnable;
            mOld = mV ? mMem[readAddress] : 32'h0;
            mA   = mOld;
            if (mV && writeEnable && readAddress == writeAddress) begin
                for (int b = 0; b < 4; b++)
                    if (writeByteEnable[b]) mA[b*8 +: 8] = writeData[b*8 +: 8];
            end
            if (mEdges >= c_DEPTH && writeEnable) begin
                for (int b = 0; b < 4; b++)
                    if (writeByteEnable[b]) mMem[writeAddress][b*8 +: 8] = writeData[b*8 +: 8];
            end
            mHistV[1] = mHistV[0]; mHistA[1] = mHistA[0]; mHistB[1] = mHistB[0];
            mHistV[0] = mV;        mHistA[0] = mA;        mHistB[0] = mOld;
            if (mEdges < c_DEPTH) mEdges = mEdges + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        chk("readyA",     {31'h0, readyA},     {31'h0, mEdges >= c_DEPTH});
        chk("readyB",     {31'h0, readyB},     {31'h0, mEdges >= c_DEPTH});
        chk("readValidA", {31'h0, readValidA}, {31'h0, mHistV[0]});
        chk("readDataA",  readDataA,           mHistA[0]);
        chk("readValidB", {31'h0, readValidB}, {31'h0, mHistV[1]});
        chk("readDataB",  readDataB,           mHistB[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic idle();
        readEnable = 1'b0; writeEnable = 1'b0; writeByteEnable = 4'h0;
        readAddress = 4'h0; writeAddress = 4'h0; writeData = 32'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        writeEnable = 1'b1; writeAddress = a; writeData = d; writeByteEnable = m;
        tick(1);
        idle();
    endtask

    // Read, optionally colliding with a same-address write, then pin each flavour at its latency.
    task automatic rdCheck(input logic [3:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] m, input logic [31:0] expA,
                           input logic [31:0] expB, input string nm);
        readEnable = 1'b1; readAddress = a;
        writeEnable = we; writeAddress = a; writeData = wd; writeByteEnable = m;
        tick(1);
        idle();
        chk({nm, "_validA"}, {31'h0, readValidA}, 32'h1);
        chk({nm, "_dataA"},  readDataA, expA);
        tick(1);
        chk({nm, "_validB"}, {31'h0, readValidB}, 32'h1);
        chk({nm, "_dataB"},  readDataB, expB);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick(2);
        reset = 1'b1;
        // Traffic during the clear must be ignored.
        readEnable = 1'b1; readAddress = 4'd5;
        writeEnable = 1'b1; writeAddress = 4'd5; writeData = 32'hDEADBEEF; writeByteEnable = 4'hF;
        tick(15);
        idle();
        chk("clear_ready_lo", {31'h0, readyA}, 32'h0);
        tick(1);
        chk("clear_ready_hi", {31'h0, readyA}, 32'h1);
        rdCheck(4'd5, 1'b0, 32'h0, 4'h0, 32'h00000000, 32'h00000000, "clear_read5");

        wr(4'd2, 32'hAABBCCDD, 4'b1111);
        rdCheck(4'd2, 1'b0, 32'h0, 4'h0, 32'hAABBCCDD, 32'hAABBCCDD, "lane_full");
        wr(4'd2, 32'h11223344, 4'b0101);
        rdCheck(4'd2, 1'b0, 32'h0, 4'h0, 32'hAA22CC44, 32'hAA22CC44, "lane_masked");
        wr(4'd6, 32'h55667788, 4'b0000);
        rdCheck(4'd6, 1'b0, 32'h0, 4'h0, 32'h00000000, 32'h00000000, "lane_nomask");

        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        rdCheck(4'd3, 1'b1, 32'h00001234, 4'b0011, 32'hAABB1234, 32'hAABBCCDD, "collide");
        rdCheck(4'd3, 1'b0, 32'h0, 4'h0, 32'hAABB1234, 32'hAABB1234, "collide_after");

        wr(4'd1, 32'h10, 4'hF);
        wr(4'd2, 32'h20, 4'hF);
        wr(4'd3, 32'h30, 4'hF);
        readEnable = 1'b1; readAddress = 4'd1;
        tick(1);
        chk("lat2_e1_valid", {31'h0, readValidB}, 32'h0);
        readAddress = 4'd2;
        writeEnable = 1'b1; writeAddress = 4'd1; writeData = 32'h99; writeByteEnable = 4'hF;
        tick(1);
        writeEnable = 1'b0;
        chk("lat2_e2_data", readDataB, 32'h10);
        chk("lat2_e2_dataA", readDataA, 32'h20);
        readAddress = 4'd3;
        tick(1);
        readEnable = 1'b0;
        chk("lat2_e3_data", readDataB, 32'h20);
        tick(1);
        chk("lat2_e4_data", readDataB, 32'h30);
        tick(1);
        chk("lat2_e5_valid", {31'h0, readValidB}, 32'h0);
        idle();

        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(7);
        reset = 1'b0;
        writeEnable = 1'b1; writeAddress = 4'd9; writeData = 32'h5A5A5A5A; writeByteEnable = 4'hF;
        readEnable = 1'b1; readAddress = 4'd9;
        tick(2);
        reset = 1'b1;
        tick(10);
        idle();
        tick(5);
        chk("restart_ready_lo", {31'h0, readyB}, 32'h0);
        tick(1);
        chk("restart_ready_hi", {31'h0, readyB}, 32'h1);
        rdCheck(4'd9, 1'b0, 32'h0, 4'h0, 32'h00000000, 32'h00000000, "restart_read9");

        wr(4'd4, 32'hCAFE0004, 4'hF);
        readEnable = 1'b1; readAddress = 4'd4;
        tick(1);
        idle();
        chk("inflight_pre_dataA", readDataA, 32'hCAFE0004);
        #1 reset = 1'b0;
        #1;
        chk("inflight_validA", {31'h0, readValidA}, 32'h0);
        chk("inflight_dataA",  readDataA, 32'h0);
        chk("inflight_validB", {31'h0, readValidB}, 32'h0);
        chk("inflight_dataB",  readDataB, 32'h0);
        tick(1);
        reset = 1'b1;
        tick(c_DEPTH + 2);
        rdCheck(4'd4, 1'b0, 32'h0, 4'h0, 32'h00000000, 32'h00000000, "post_reset_read4");
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
